// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-bus definitions for the two-requester arbiter: region codes,
// access size codes, FSM state encoding, requester indices and wait-counter width.
package mem_bus_arbiter_pkg;

  localparam int WS_W = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    REG_ROM    = 2'b00,
    REG_RAM    = 2'b01,
    REG_PERIF  = 2'b10,
    REG_UNUSED = 2'b11
  } region_e;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-bus signal bundle for mem_bus_arbiter.
//   req/we/size/addr/wdata : per-requester request (bit/field 0 = CPU, 1 = DMA)
//   ack/err/rdata          : completion pulse, error flag, shared read data
//   mem_*                  : downstream memory bus
// slave  : arbiter view
// master : requester/memory environment view
interface mem_bus_arbiter_if;
  logic [1:0]   req;
  logic [1:0]   we;
  logic [3:0]   size;
  logic [63:0]  addr;
  logic [127:0] wdata;
  logic [1:0]   ack;
  logic [1:0]   err;
  logic [63:0]  rdata;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [1:0]   mem_size;
  logic [63:0]  mem_rdata;
  logic         mem_en;
  logic         mem_write_en;
  logic [1:0]   mem_cs;

  modport slave (
    input  req, we, size, addr, wdata, mem_rdata,
    output ack, err, rdata, mem_address, mem_wdata, mem_size,
           mem_en, mem_write_en, mem_cs
  );

  modport master (
    output req, we, size, addr, wdata, mem_rdata,
    input  ack, err, rdata, mem_address, mem_wdata, mem_size,
           mem_en, mem_write_en, mem_cs
  );
endinterface

// File: rtl/mem_region_decode.sv
// Address/size decoder: region chip select from addr[13:12], wait-state count
// for that region, and an error flag for the UNUSED region or misalignment.
//   addr_region : address bits [13:12]
//   addr_low    : address bits [2:0] (alignment check)
//   size        : access size code
//   cs / ws / err : region, wait cycles, access error
module mem_region_decode
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ROM_WS   = 1,
  parameter int unsigned RAM_WS   = 0,
  parameter int unsigned PERIF_WS = 2
) (
  input  logic [1:0]      addr_region,
  input  logic [2:0]      addr_low,
  input  logic [1:0]      size,
  output region_e         cs,
  output logic [WS_W-1:0] ws,
  output logic            err
);

  logic misaligned;

  always_comb begin
    cs = region_e'(addr_region);

    unique case (size_e'(size))
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_low[0];
      SZ_WORD: misaligned = |addr_low[1:0];
      default: misaligned = |addr_low[2:0];
    endcase

    unique case (cs)
      REG_ROM:   ws = WS_W'(ROM_WS);
      REG_RAM:   ws = WS_W'(RAM_WS);
      REG_PERIF: ws = WS_W'(PERIF_WS);
      default:   ws = '0;
    endcase

    err = (cs == REG_UNUSED) || misaligned;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU/DMA) round-robin memory bus arbiter with per-region wait
// states. IDLE grants and latches one request, ACCESS drives the bus for
// WS+1 cycles, RESP returns ack/err/rdata to the granted requester.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : requester + memory bus bundle (slave view)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ROM_WS   = 1,
  parameter int unsigned RAM_WS   = 0,
  parameter int unsigned PERIF_WS = 2
) (
  input  logic             clock,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);

  state_e          state, state_nxt;
  logic            take;
  logic            gnt_nxt, gnt, last_gnt;
  logic [31:0]     sel_addr;
  logic [1:0]      sel_size;
  logic            sel_we;
  logic [63:0]     sel_wdata;
  region_e         dec_cs;
  logic [WS_W-1:0] dec_ws;
  logic            dec_err;

  logic            we_lat, err_lat;
  region_e         cs_lat;
  logic [31:0]     addr_lat;
  logic [1:0]      size_lat;
  logic [63:0]     wdata_lat;
  logic [WS_W-1:0] cnt;
  logic [63:0]     rdata_q;
  logic [1:0]      ack_q, err_q, ack_nxt, err_nxt;
  logic            mem_en_c, mem_write_en_c;
  logic [1:0]      mem_cs_c;

  // Round robin: a tie goes to whoever was not granted last; a lone request wins.
  always_comb begin
    if (bus.req == 2'b11) gnt_nxt = ~last_gnt;
    else                  gnt_nxt = bus.req[1];
  end

  assign take      = (state == ST_IDLE) && (|bus.req);
  assign sel_addr  = gnt_nxt ? bus.addr[63:32]   : bus.addr[31:0];
  assign sel_size  = gnt_nxt ? bus.size[3:2]     : bus.size[1:0];
  assign sel_we    = gnt_nxt ? bus.we[1]         : bus.we[0];
  assign sel_wdata = gnt_nxt ? bus.wdata[127:64] : bus.wdata[63:0];

  mem_region_decode #(
    .ROM_WS   (ROM_WS),
    .RAM_WS   (RAM_WS),
    .PERIF_WS (PERIF_WS)
  ) u_decode (
    .addr_region (sel_addr[13:12]),
    .addr_low    (sel_addr[2:0]),
    .size        (sel_size),
    .cs          (dec_cs),
    .ws          (dec_ws),
    .err         (dec_err)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (take) state_nxt = dec_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ack/err are registered off RESP, so they are seen in the cycle after RESP.
  always_comb begin
    mem_en_c       = 1'b0;
    mem_write_en_c = 1'b0;
    mem_cs_c       = '0;
    ack_nxt        = '0;
    err_nxt        = '0;
    unique case (state)
      ST_ACCESS: begin
        mem_en_c       = 1'b1;
        mem_write_en_c = we_lat;
        mem_cs_c       = cs_lat;
      end
      ST_RESP: begin
        ack_nxt[gnt] = 1'b1;
        err_nxt[gnt] = err_lat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt       <= REQ_CPU;
      last_gnt  <= REQ_DMA;
      we_lat    <= 1'b0;
      err_lat   <= 1'b0;
      cs_lat    <= REG_ROM;
      addr_lat  <= '0;
      size_lat  <= '0;
      wdata_lat <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
    end else begin
      ack_q <= ack_nxt;
      err_q <= err_nxt;
      if (take) begin
        gnt       <= gnt_nxt;
        last_gnt  <= gnt_nxt;
        we_lat    <= sel_we;
        err_lat   <= dec_err;
        cs_lat    <= dec_cs;
        addr_lat  <= sel_addr;
        size_lat  <= sel_size;
        wdata_lat <= sel_wdata;
        cnt       <= dec_ws;
      end
      if (state == ST_ACCESS) begin
        if (cnt != '0)   cnt     <= cnt - WS_W'(1);
        else if (!we_lat) rdata_q <= bus.mem_rdata;
      end
      if (state == ST_RESP && err_lat) rdata_q <= '0;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.mem_address  = addr_lat;
  assign bus.mem_wdata    = wdata_lat;
  assign bus.mem_size     = size_lat;
  assign bus.mem_en       = mem_en_c;
  assign bus.mem_write_en = mem_write_en_c;
  assign bus.mem_cs       = mem_cs_c;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (ROM_WS=1, RAM_WS=0, PERIF_WS=2).
module tb_mem_bus_arbiter;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(
    .ROM_WS   (1),
    .RAM_WS   (0),
    .PERIF_WS (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request from requester r while the arbiter is idle, drop req
  // after the grant edge, and check bus activity, latency and response.
  task automatic run_txn(input string nm, input int unsigned r, input logic w,
                         input logic [1:0] sz, input logic [31:0] a,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input int unsigned ws, input logic e,
                         input logic [1:0] cs, input logic [63:0] exp_rd);
    int unsigned k, en_cnt, wen_cnt;
    logic [1:0]  cs_seen, sz_seen;
    logic [31:0] a_seen;
    logic [63:0] wd_seen;
    bit          done;
    bus.we[r]            = w;
    bus.size[2*r +: 2]   = sz;
    bus.addr[32*r +: 32] = a;
    bus.wdata[64*r +: 64] = wd;
    bus.mem_rdata        = rd;
    bus.req[r]           = 1'b1;
    tick();
    bus.req[r] = 1'b0;
    k = 0; en_cnt = 0; wen_cnt = 0; done = 0;
    cs_seen = '0; sz_seen = '0; a_seen = '0; wd_seen = '0;
    while (!done && k < 20) begin
      if (bus.mem_en) begin
        en_cnt++;
        if (bus.mem_write_en) wen_cnt++;
        cs_seen = bus.mem_cs;
        sz_seen = bus.mem_size;
        a_seen  = bus.mem_address;
        wd_seen = bus.mem_wdata;
      end
      if (bus.ack != 2'b00) done = 1;
      else begin
        tick();
        k++;
      end
    end
    if (!done) check({nm, ".timeout"}, 64'd0, 64'd1);
    check({nm, ".lat"}, 64'(k), e ? 64'd1 : 64'(ws + 2));
    check({nm, ".ack"}, 64'(bus.ack), 64'(2'b01 << r));
    check({nm, ".err"}, 64'(bus.err), e ? 64'(2'b01 << r) : 64'd0);
    check({nm, ".rdata"}, bus.rdata, exp_rd);
    check({nm, ".en_cycles"}, 64'(en_cnt), e ? 64'd0 : 64'(ws + 1));
    check({nm, ".wen_cycles"}, 64'(wen_cnt), (e || !w) ? 64'd0 : 64'(ws + 1));
    if (!e) begin
      check({nm, ".cs"}, 64'(cs_seen), 64'(cs));
      check({nm, ".addr"}, 64'(a_seen), 64'(a));
      check({nm, ".size"}, 64'(sz_seen), 64'(sz));
      if (w) check({nm, ".wdata"}, wd_seen, wd);
    end
    tick();
    check({nm, ".ack_pulse"}, 64'(bus.ack), 64'd0);
  endtask

  task automatic check_quiet(input string nm);
    check({nm, ".ack"}, 64'(bus.ack), 64'd0);
    check({nm, ".err"}, 64'(bus.err), 64'd0);
    check({nm, ".rdata"}, bus.rdata, 64'd0);
    check({nm, ".mem_en"}, 64'(bus.mem_en), 64'd0);
    check({nm, ".mem_wen"}, 64'(bus.mem_write_en), 64'd0);
    check({nm, ".mem_cs"}, 64'(bus.mem_cs), 64'd0);
    check({nm, ".mem_addr"}, 64'(bus.mem_address), 64'd0);
    check({nm, ".mem_wdata"}, bus.mem_wdata, 64'd0);
    check({nm, ".mem_size"}, 64'(bus.mem_size), 64'd0);
  endtask

  initial begin
    logic [1:0] order [4];
    logic [1:0] exp_order [4];
    int unsigned n_ack;
    n_checks = 0;
    n_errors = 0;
    reset         = 1'b0;
    bus.req       = '0;
    bus.we        = '0;
    bus.size      = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_rdata = '0;
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
    foreach (order[i]) order[i] = '0;

    tick();
    tick();
    check_quiet("reset");
    reset = 1'b1;
    tick();

    // Continuous requests from both: round robin CPU, DMA, CPU, DMA.
    bus.size      = {2'b10, 2'b10};
    bus.addr      = {32'h0000_1100, 32'h0000_1000};
    bus.mem_rdata = 64'h0000_0000_0000_0042;
    bus.req       = 2'b11;
    n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      tick();
      if (bus.ack != 2'b00) begin
        order[n_ack] = bus.ack;
        n_ack++;
        if (n_ack == 4) bus.req = 2'b00;
      end
    end
    bus.req = 2'b00;
    check("rr.count", 64'(n_ack), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr.grant%0d", i), 64'(order[i]), 64'(exp_order[i]));
    tick();

    // CPU double read from RAM (no wait states).
    run_txn("cpu_ram_rd", 0, 1'b0, 2'b11, 32'h0000_1008, 64'd0,
            64'h0000_0000_DEAD_BEEF, 0, 1'b0, 2'b01, 64'h0000_0000_DEAD_BEEF);
    // DMA word write to PERIF (2 wait states); rdata must keep the last read.
    run_txn("dma_perif_wr", 1, 1'b1, 2'b10, 32'h0000_2010, 64'h55,
            64'h0000_0000_0000_0099, 2, 1'b0, 2'b10, 64'h0000_0000_DEAD_BEEF);
    // Unused region and misaligned half-word: error, no bus access, rdata 0.
    run_txn("cpu_unused", 0, 1'b0, 2'b00, 32'h0000_3000, 64'd0,
            64'h1111, 0, 1'b1, 2'b00, 64'd0);
    run_txn("cpu_misalign", 0, 1'b0, 2'b01, 32'h0000_1003, 64'd0,
            64'h2222, 0, 1'b1, 2'b00, 64'd0);
    // ROM half read (1 wait state).
    run_txn("cpu_rom_rd", 0, 1'b0, 2'b01, 32'h0000_0100, 64'd0,
            64'h1234, 1, 1'b0, 2'b00, 64'h1234);

    // Reset asserted in the middle of a ROM access.
    bus.size[1:0] = 2'b10;
    bus.addr[31:0] = 32'h0000_0200;
    bus.mem_rdata = 64'h7777;
    bus.req[0] = 1'b1;
    tick();
    bus.req[0] = 1'b0;
    check("rst.pre_en", 64'(bus.mem_en), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_quiet("rst.async");
    tick();
    check("rst.hold_ack0", 64'(bus.ack), 64'd0);
    tick();
    check("rst.hold_ack1", 64'(bus.ack), 64'd0);
    reset = 1'b1;
    run_txn("post_rst_dma", 1, 1'b0, 2'b10, 32'h0000_1040, 64'd0,
            64'h0000_0000_CAFE_F00D, 0, 1'b0, 2'b01, 64'h0000_0000_CAFE_F00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ROM_WS, default 1, wait cycles for ROM region.
REQ-002 SHALL have parameter RAM_WS, default 0, wait cycles for RAM region.
REQ-003 SHALL have parameter PERIF_WS, default 2, wait cycles for peripheral region.
REQ-004 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  in  2  access request; bit0 = CPU, bit1 = DMA.
REQ-007 SHALL have port we  in  2  per-requester write enable (1 = store).
REQ-008 SHALL have port size  in  4  per-requester size, 2 bits each: 00 byte, 01 half, 10 word, 11 double.
REQ-009 SHALL have port addr  in  64  per-requester byte address, 32 bits each, bits[31:0] = CPU.
REQ-010 SHALL have port wdata  in  128  per-requester write data, 64 bits each.
REQ-011 SHALL have port ack  out  2  one-cycle completion pulse to granted requester.
REQ-012 SHALL have port err  out  2  error flag, valid only with matching ack bit.
REQ-013 SHALL have port rdata  out  64  read data, shared, valid with ack.
REQ-014 SHALL have ports mem_address out 32, mem_wdata out 64, mem_size out 2: bus address, store data, access size.
REQ-015 SHALL have port mem_rdata  in  64  bus read data, sampled on final access cycle.
REQ-016 SHALL have ports mem_en out 1, mem_write_en out 1: bus access strobe, write qualifier.
REQ-017 SHALL have port mem_cs  out  2  chip select: 00 ROM, 01 RAM, 10 PERIF, 11 UNUSED.

Function
REQ-018 SHALL decode region from address bits[13:12]: 00 ROM, 01 RAM, 10 PERIF, 11 UNUSED.
REQ-019 SHALL implement states IDLE, ACCESS, RESP; reset state IDLE.
REQ-020 SHALL, in IDLE with any req bit set, grant one requester, latch its addr/we/wdata/size, go ACCESS.
REQ-021 SHALL arbitrate round-robin: on simultaneous requests grant the requester not granted last; after reset CPU wins first tie.
REQ-022 SHALL, in ACCESS, hold mem_en=1, mem_write_en=latched we, mem_cs=region, and load a wait counter with the region WS on entry.
REQ-023 SHALL stay in ACCESS until counter is 0, decrementing each cycle; on counter 0 capture mem_rdata into rdata and go RESP.
REQ-024 SHALL, in RESP, pulse ack[granted]=1 for exactly one cycle, then return to IDLE; ack never asserted to both requesters.
REQ-025 SHALL give latency: req sampled in IDLE at edge N -> ack high during cycle after edge N+2+WS.
REQ-026 SHALL treat UNUSED region or misaligned address (addr not multiple of 2^size) as error: skip ACCESS, mem_en stays 0, RESP with err=1, rdata=0.
REQ-027 SHALL complete a granted access even if req drops mid-transaction; ack still pulses.
REQ-028 SHALL re-arbitrate only in IDLE; a request arriving during ACCESS/RESP waits (one idle cycle between back-to-back transactions).
REQ-029 SHALL drive mem_en, mem_write_en to 0 and mem_cs to 00 outside ACCESS; rdata unchanged for store transactions.

Reset
REQ-030 SHALL on reset low force IDLE, ack=0, err=0, rdata=0, mem_en=0, mem_write_en=0, mem_cs=00, mem_address=0, mem_wdata=0, mem_size=00, counter=0, last-grant=DMA, aborting any access immediately.
REQ-031 SHALL resume arbitration on the first rising clock edge after reset returns high.

Structure
REQ-032 SHALL place region codes, size codes, state encoding in a shared memory-bus package used by control unit and datapath.
REQ-033 SHALL use one sub-module, mem_region_decode (address+size -> mem_cs, wait count, error); rest is the FSM.

Verification
REQ-034 SHALL test CPU read 0x1008 size 11 (RAM, WS 0), mem_rdata=0xDEADBEEF -> ack[0] 2 cycles after grant, rdata=0xDEADBEEF, err=0.
REQ-035 SHALL test simultaneous CPU/DMA requests after reset, repeated twice -> grant order CPU, DMA, CPU, DMA.
REQ-036 SHALL test DMA write 0x2010 size 10 data 0x55 (PERIF, WS 2) -> mem_en+mem_write_en high 3 cycles, mem_cs=10, ack[1] after.
REQ-037 SHALL test CPU read 0x3000 (UNUSED) and 0x1003 size 01 (misaligned) -> mem_en never high, ack[0] with err[0]=1, rdata=0.
REQ-038 SHALL test reset low mid-ACCESS on ROM read -> all outputs zero at once, no ack, next request served normally.
